// File: rtl/load_value_predictor.sv
// load_value_predictor
//
// Direct-mapped, tagged load value prediction table. A load in EX looks up its
// PC and gets a registered prediction one cycle later. A load retiring from MEM
// trains the entry with its real data. Each entry has a saturating confidence
// counter. A prediction is issued only when that counter reaches CONF_THRESHOLD.
// After reset or a flush the table is swept one entry per cycle. ready_o stays
// low until the sweep completes.
//
// Optional feature: define LVPT_STRIDE_EN to give every entry a stride. The
// prediction is then value + stride.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush_i                 invalidate the whole table (restart the sweep)
//   ready_o                 table usable (not clearing)
//   lookup_valid_i/pc_i     prediction request from EX
//   pred_valid_o            response strobe, one cycle after an accepted lookup
//   pred_taken_o            a prediction was issued
//   pred_data_o             predicted value (0 when not taken)
//   upd_valid_i/pc_i/data_i training update from MEM with the real loaded value
//   upd_predicted_i         a prediction was consumed for this load
//   upd_pred_data_i         the value that was consumed
//   mispredict_o            registered: consumed prediction was wrong

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module load_value_predictor #(
    parameter int INDEX_WIDTH    = 8,
    parameter int CONF_WIDTH     = 2,
    parameter int CONF_THRESHOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    output logic                   ready_o,
    input  logic                   lookup_valid_i,
    input  logic [`ADDR_WIDTH-1:0] lookup_pc_i,
    output logic                   pred_valid_o,
    output logic                   pred_taken_o,
    output logic [`DATA_WIDTH-1:0] pred_data_o,
    input  logic                   upd_valid_i,
    input  logic [`ADDR_WIDTH-1:0] upd_pc_i,
    input  logic [`DATA_WIDTH-1:0] upd_data_i,
    input  logic                   upd_predicted_i,
    input  logic [`DATA_WIDTH-1:0] upd_pred_data_i,
    output logic                   mispredict_o
);

    localparam int DEPTH     = 2 ** INDEX_WIDTH;
    localparam int TAG_WIDTH = `ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam int DW        = `DATA_WIDTH;

    localparam logic [CONF_WIDTH-1:0]  CONF_MAX = '1;
    localparam logic [CONF_WIDTH-1:0]  CONF_THR = CONF_WIDTH'(CONF_THRESHOLD);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] clr_idx;

    // Table storage. It has no reset: the sweep after reset is what
    // invalidates it, and it cannot be read or trained before then.
    logic                  valid_mem [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem   [DEPTH];
    logic [DW-1:0]         value_mem [DEPTH];
    logic [CONF_WIDTH-1:0] conf_mem  [DEPTH];
`ifdef LVPT_STRIDE_EN
    logic [DW-1:0]         stride_mem [DEPTH];
`endif

    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [INDEX_WIDTH-1:0] up_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic [TAG_WIDTH-1:0]   up_tag;
    logic [DW-1:0]          lk_pred;
    logic [DW-1:0]          up_pred;
    logic                   lk_taken;
    logic                   lk_accept;
    logic                   up_hit;
    logic                   up_match;
    logic                   upd_en;
    logic                   unused_pc_bits;

    assign lk_idx = lookup_pc_i[INDEX_WIDTH+1:2];
    assign lk_tag = lookup_pc_i[`ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign up_idx = upd_pc_i[INDEX_WIDTH+1:2];
    assign up_tag = upd_pc_i[`ADDR_WIDTH-1:INDEX_WIDTH+2];

    // Loads are word aligned, so the byte offset bits play no part.
    assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

`ifdef LVPT_STRIDE_EN
    assign lk_pred = value_mem[lk_idx] + stride_mem[lk_idx];
    assign up_pred = value_mem[up_idx] + stride_mem[up_idx];
`else
    assign lk_pred = value_mem[lk_idx];
    assign up_pred = value_mem[up_idx];
`endif

    assign ready_o   = (state == ST_RUN);
    assign lk_accept = lookup_valid_i && ready_o;
    assign lk_taken  = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag) &&
                       (conf_mem[lk_idx] >= CONF_THR);
    assign up_hit    = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
    assign up_match  = (up_pred == upd_data_i);
    // A flush wins over a same-cycle update, so that update is dropped.
    assign upd_en    = upd_valid_i && ready_o && !flush_i;

    // Sweep control. A flush restarts the sweep from entry 0, even when
    // a sweep is already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else if (flush_i) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + INDEX_WIDTH'(1);
            if (clr_idx == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    // Registered prediction response. The table is read before the
    // same-edge update writes it, so a colliding update is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_data_o  <= '0;
            mispredict_o <= 1'b0;
        end else begin
            pred_valid_o <= lk_accept;
            pred_taken_o <= lk_accept && lk_taken;
            pred_data_o  <= (lk_accept && lk_taken) ? lk_pred : '0;
            mispredict_o <= upd_valid_i && upd_predicted_i &&
                            (upd_pred_data_i != upd_data_i);
        end
    end

    // Table write port: the sweep zeroes one entry per cycle. Otherwise an
    // accepted update allocates the entry, raises confidence on a correct
    // prediction, or retrains it on a wrong one.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            valid_mem[clr_idx]  <= 1'b0;
            tag_mem[clr_idx]    <= '0;
            value_mem[clr_idx]  <= '0;
            conf_mem[clr_idx]   <= '0;
`ifdef LVPT_STRIDE_EN
            stride_mem[clr_idx] <= '0;
`endif
        end else if (upd_en) begin
            if (!up_hit) begin
                valid_mem[up_idx]  <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                value_mem[up_idx]  <= upd_data_i;
                conf_mem[up_idx]   <= '0;
`ifdef LVPT_STRIDE_EN
                stride_mem[up_idx] <= '0;
`endif
            end else if (up_match) begin
                if (conf_mem[up_idx] != CONF_MAX) begin
                    conf_mem[up_idx] <= conf_mem[up_idx] + CONF_WIDTH'(1);
                end
                value_mem[up_idx] <= upd_data_i;
            end else begin
                conf_mem[up_idx]   <= '0;
                value_mem[up_idx]  <= upd_data_i;
`ifdef LVPT_STRIDE_EN
                stride_mem[up_idx] <= upd_data_i - value_mem[up_idx];
`endif
            end
        end
    end

endmodule

// File: tb/tb_load_value_predictor.sv
// tb_load_value_predictor
//
// Self-checking bench for load_value_predictor. A reference model of the table
// is kept as an array of entry records, and a countdown of the cycles left until
// the table becomes ready. The model is advanced on every clock edge. One
// process compares every DUT output against the model on each falling edge.
// Directed scenarios pin known literal values. A randomized phase follows, with
// occasional flushes and one reset in mid-run. Honours LVPT_STRIDE_EN.

`timescale 1ns/1ps

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_load_value_predictor;

    localparam int INDEX_WIDTH    = 8;
    localparam int CONF_WIDTH     = 2;
    localparam int CONF_THRESHOLD = 2;
    localparam int DEPTH          = 2 ** INDEX_WIDTH;
    localparam int AW             = `ADDR_WIDTH;
    localparam int DW             = `DATA_WIDTH;
    localparam int CONF_MAX       = 2 ** CONF_WIDTH - 1;

    logic          clk             = 1'b0;
    logic          rst_n           = 1'b0;
    logic          flush_i         = 1'b0;
    logic          lookup_valid_i  = 1'b0;
    logic [AW-1:0] lookup_pc_i     = '0;
    logic          upd_valid_i     = 1'b0;
    logic [AW-1:0] upd_pc_i        = '0;
    logic [DW-1:0] upd_data_i      = '0;
    logic          upd_predicted_i = 1'b0;
    logic [DW-1:0] upd_pred_data_i = '0;
    logic          ready_o;
    logic          pred_valid_o;
    logic          pred_taken_o;
    logic [DW-1:0] pred_data_o;
    logic          mispredict_o;

    always #5 clk = ~clk;

    load_value_predictor #(
        .INDEX_WIDTH   (INDEX_WIDTH),
        .CONF_WIDTH    (CONF_WIDTH),
        .CONF_THRESHOLD(CONF_THRESHOLD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .ready_o        (ready_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_data_o    (pred_data_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_data_i     (upd_data_i),
        .upd_predicted_i(upd_predicted_i),
        .upd_pred_data_i(upd_pred_data_i),
        .mispredict_o   (mispredict_o)
    );

    typedef struct {
        bit            valid;
        logic [AW-1:0] tag;
        logic [DW-1:0] value;
        logic [DW-1:0] stride;
        int            conf;
    } entry_t;

    entry_t        model_tbl [DEPTH];
    int            remaining = DEPTH;
    logic          exp_ready = 1'b0;
    logic          exp_pv    = 1'b0;
    logic          exp_taken = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic          exp_mis   = 1'b0;
    int            n_checks  = 0;
    int            n_fail    = 0;

    function automatic int idx_of(input logic [AW-1:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] pc);
        return pc / (DEPTH * 4);
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] pc);
        return model_tbl[idx_of(pc)].valid && (model_tbl[idx_of(pc)].tag == tag_of(pc));
    endfunction

    function automatic logic [DW-1:0] model_pred(input logic [AW-1:0] pc);
        return model_tbl[idx_of(pc)].value + model_tbl[idx_of(pc)].stride;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            model_tbl[i].valid  = 1'b0;
            model_tbl[i].tag    = '0;
            model_tbl[i].value  = '0;
            model_tbl[i].stride = '0;
            model_tbl[i].conf   = 0;
        end
    endfunction

    function automatic void model_update(input logic [AW-1:0] pc, input logic [DW-1:0] data);
        int e;
        e = idx_of(pc);
        if (!model_hit(pc)) begin
            model_tbl[e].valid  = 1'b1;
            model_tbl[e].tag    = tag_of(pc);
            model_tbl[e].value  = data;
            model_tbl[e].stride = '0;
            model_tbl[e].conf   = 0;
        end else if (model_pred(pc) == data) begin
            if (model_tbl[e].conf < CONF_MAX) model_tbl[e].conf++;
            model_tbl[e].value = data;
        end else begin
`ifdef LVPT_STRIDE_EN
            model_tbl[e].stride = data - model_tbl[e].value;
`endif
            model_tbl[e].value = data;
            model_tbl[e].conf  = 0;
        end
    endfunction

    // Reference model: compute the outputs expected after this edge from the
    // inputs that were present before it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining = DEPTH;
            clear_model();
            exp_ready = 1'b0;
            exp_pv    = 1'b0;
            exp_taken = 1'b0;
            exp_data  = '0;
            exp_mis   = 1'b0;
        end else begin
            bit ready_now;
            ready_now = (remaining == 0);
            exp_pv    = lookup_valid_i && ready_now;
            exp_taken = exp_pv && model_hit(lookup_pc_i) &&
                        (model_tbl[idx_of(lookup_pc_i)].conf >= CONF_THRESHOLD);
            exp_data  = exp_taken ? model_pred(lookup_pc_i) : '0;
            exp_mis   = upd_valid_i && upd_predicted_i && (upd_pred_data_i != upd_data_i);
            if (ready_now && upd_valid_i && !flush_i) model_update(upd_pc_i, upd_data_i);
            if (flush_i) begin
                remaining = DEPTH;
                clear_model();
            end else if (remaining > 0) begin
                remaining--;
            end
            exp_ready = (remaining == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("ready_o", 64'(ready_o), 64'(exp_ready));
        checkOutput("pred_valid_o", 64'(pred_valid_o), 64'(exp_pv));
        checkOutput("pred_taken_o", 64'(pred_taken_o), 64'(exp_taken));
        checkOutput("pred_data_o", 64'(pred_data_o), 64'(exp_data));
        checkOutput("mispredict_o", 64'(mispredict_o), 64'(exp_mis));
    end

    // Present one cycle of inputs, return just after the edge that sampled them.
    task automatic applyStimulus(input logic lv, input logic [AW-1:0] lpc,
                                 input logic uv, input logic [AW-1:0] upc,
                                 input logic [DW-1:0] udata, input logic upred,
                                 input logic [DW-1:0] updata, input logic fl);
        lookup_valid_i  = lv;
        lookup_pc_i     = lpc;
        upd_valid_i     = uv;
        upd_pc_i        = upc;
        upd_data_i      = udata;
        upd_predicted_i = upred;
        upd_pred_data_i = updata;
        flush_i         = fl;
        @(posedge clk);
        #1;
        lookup_valid_i  = 1'b0;
        upd_valid_i     = 1'b0;
        upd_predicted_i = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic doUpdate(input logic [AW-1:0] pc, input logic [DW-1:0] data,
                            input logic predicted, input logic [DW-1:0] pdata);
        applyStimulus(1'b0, '0, 1'b1, pc, data, predicted, pdata, 1'b0);
    endtask

    task automatic doLookup(input logic [AW-1:0] pc);
        applyStimulus(1'b1, pc, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [AW-1:0] rand_pc();
        int t;
        int i;
        t = $urandom_range(1, 3);
        i = ($urandom_range(0, 1) == 0) ? 3 : 7;
        return AW'(t * DEPTH * 4 + i * 4 + int'($urandom_range(0, 3)));
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] upc;
        logic [DW-1:0] udata;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 64'(ready_o), 64'd0);
        checkOutput("reset_pred_valid", 64'(pred_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep after reset: lookups are ignored, and ready rises on edge 256.
        for (int i = 1; i <= DEPTH; i++) begin
            doLookup(AW'('h400100));
            checkOutput("sweep_pred_valid", 64'(pred_valid_o), 64'd0);
            checkOutput("sweep_ready", 64'(ready_o), (i == DEPTH) ? 64'd1 : 64'd0);
        end

        // Train to threshold, then predict.
        doUpdate(AW'('h400100), DW'('h55), 1'b0, '0);
        doLookup(AW'('h400100));
        checkOutput("conf0_taken", 64'(pred_taken_o), 64'd0);
        doUpdate(AW'('h400100), DW'('h55), 1'b0, '0);
        doUpdate(AW'('h400100), DW'('h55), 1'b0, '0);
        doLookup(AW'('h400100));
        checkOutput("trained_valid", 64'(pred_valid_o), 64'd1);
        checkOutput("trained_taken", 64'(pred_taken_o), 64'd1);
        checkOutput("trained_data", 64'(pred_data_o), 64'h55);

        // A wrong consumed prediction flags a mispredict and resets confidence.
        doUpdate(AW'('h400100), DW'('h66), 1'b1, DW'('h55));
        checkOutput("mispredict", 64'(mispredict_o), 64'd1);
        doLookup(AW'('h400100));
        checkOutput("after_mis_taken", 64'(pred_taken_o), 64'd0);
        checkOutput("after_mis_data", 64'(pred_data_o), 64'd0);
        doUpdate(AW'('h400100), DW'('h66), 1'b1, DW'('h66));
        checkOutput("correct_no_mis", 64'(mispredict_o), 64'd0);

        // Same index with a new tag reallocates the entry.
        repeat (3) doUpdate(AW'('h400200), DW'('h77), 1'b0, '0);
        doLookup(AW'('h400200));
        checkOutput("alias_trained", 64'(pred_taken_o), 64'd1);
        doUpdate(AW'('h800200), DW'('h99), 1'b0, '0);
        doLookup(AW'('h400200));
        checkOutput("alias_evicted", 64'(pred_taken_o), 64'd0);
        doLookup(AW'('h800200));
        checkOutput("alias_new_conf0", 64'(pred_taken_o), 64'd0);

        // A lookup and an update to the same entry in one cycle see the old contents.
        repeat (2) doUpdate(AW'('h400500), DW'('h31), 1'b0, '0);
        applyStimulus(1'b1, AW'('h400500), 1'b1, AW'('h400500), DW'('h31), 1'b0, '0, 1'b0);
        checkOutput("rbw_old_conf", 64'(pred_taken_o), 64'd0);
        doLookup(AW'('h400500));
        checkOutput("rbw_new_conf", 64'(pred_taken_o), 64'd1);

`ifdef LVPT_STRIDE_EN
        // Stride learning: 0x10,0x14,... then saturating confidence.
        for (int k = 0; k < 5; k++) doUpdate(AW'('h400300), DW'('h10 + 4 * k), 1'b0, '0);
        doLookup(AW'('h400300));
        checkOutput("stride_taken", 64'(pred_taken_o), 64'd1);
        checkOutput("stride_data", 64'(pred_data_o), 64'h24);
        for (int k = 0; k < 10; k++) doUpdate(AW'('h400300), DW'('h24 + 4 * k), 1'b0, '0);
        doLookup(AW'('h400300));
        checkOutput("stride_sat_taken", 64'(pred_taken_o), 64'd1);
        checkOutput("stride_sat_data", 64'(pred_data_o), 64'h4C);
        doUpdate(AW'('h400300), DW'('h4C), 1'b0, '0);
        doLookup(AW'('h400300));
        checkOutput("stride_sat_hold", 64'(pred_taken_o), 64'd1);
`endif

        // Flush a trained table: the table is cleared for 256 cycles, and every entry is then cold.
        repeat (3) doUpdate(AW'('h400400), DW'('h12), 1'b0, '0);
        doLookup(AW'('h400400));
        checkOutput("preflush_taken", 64'(pred_taken_o), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, AW'('h400600), DW'('h1), 1'b0, '0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            doLookup(AW'('h400400));
            checkOutput("flush_ready", 64'(ready_o), (i == DEPTH) ? 64'd1 : 64'd0);
            checkOutput("flush_pred_valid", 64'(pred_valid_o), 64'd0);
        end
        doLookup(AW'('h400400));
        checkOutput("postflush_valid", 64'(pred_valid_o), 64'd1);
        checkOutput("postflush_taken", 64'(pred_taken_o), 64'd0);
        doLookup(AW'('h400100));
        checkOutput("postflush_taken2", 64'(pred_taken_o), 64'd0);

        // Randomized traffic over a small set of colliding PCs.
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                doUpdate(AW'('h400100), DW'('h5), 1'b1, DW'('h6));
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("midreset_ready", 64'(ready_o), 64'd0);
                checkOutput("midreset_mis", 64'(mispredict_o), 64'd0);
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
            upc = rand_pc();
            if (model_hit(upc) && $urandom_range(0, 99) < 70) udata = model_pred(upc);
            else udata = DW'($urandom_range(0, 3) * 16);
            applyStimulus(1'($urandom_range(0, 1)), rand_pc(),
                          1'($urandom_range(0, 1)), upc, udata,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 0) ? udata : (udata ^ DW'(1)),
                          1'($urandom_range(0, 599) == 0));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_value_predictor.md
LOAD_VALUE_PREDICTOR -- requirements
Module: load_value_predictor

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 8: table index bits; depth DEPTH = 2**INDEX_WIDTH.
REQ-002 SHALL have parameter CONF_WIDTH, default 2: saturating confidence counter width.
REQ-003 SHALL have parameter CONF_THRESHOLD, default 2: minimum confidence that yields a prediction.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, request to invalidate the whole table.
REQ-007 SHALL have port ready_o, output, 1, table usable (not clearing).
REQ-008 SHALL have port lookup_valid_i, input, 1, load in EX requests a prediction.
REQ-009 SHALL have port lookup_pc_i, input, `ADDR_WIDTH, PC of that load.
REQ-010 SHALL have port pred_valid_o, output, 1, response strobe.
REQ-011 SHALL have port pred_taken_o, output, 1, prediction issued.
REQ-012 SHALL have port pred_data_o, output, `DATA_WIDTH, predicted value.
REQ-013 SHALL have port upd_valid_i, input, 1, load retired from MEM with real data.
REQ-014 SHALL have port upd_pc_i, input, `ADDR_WIDTH, PC of that load.
REQ-015 SHALL have port upd_data_i, input, `DATA_WIDTH, actual loaded value.
REQ-016 SHALL have port upd_predicted_i, input, 1, a prediction was consumed for this load.
REQ-017 SHALL have port upd_pred_data_i, input, `DATA_WIDTH, value that was predicted.
REQ-018 SHALL have port mispredict_o, output, 1, consumed prediction was wrong; pipeline recovers.

Function
REQ-019 SHALL decode index = pc[INDEX_WIDTH+1:2] and tag = pc[`ADDR_WIDTH-1:INDEX_WIDTH+2]; each entry holds valid, tag, value, conf.
REQ-020 SHALL run a two-state FSM, CLEAR and RUN, with ready_o = (state == RUN).
REQ-021 In CLEAR, SHALL zero entry clr_idx each cycle and increment it; at clr_idx == DEPTH-1 SHALL move to RUN; a full sweep takes DEPTH cycles.
REQ-022 flush_i in RUN SHALL enter CLEAR with clr_idx = 0; flush_i in CLEAR SHALL restart the sweep at 0.
REQ-023 lookup_valid_i && ready_o SHALL give pred_valid_o = 1 exactly one cycle later; otherwise pred_valid_o = 0.
REQ-024 pred_taken_o SHALL be 1 iff the entry is valid, the tag matches and conf >= CONF_THRESHOLD.
REQ-025 pred_data_o SHALL be the predicted value when pred_taken_o = 1, else 0.
REQ-026 upd_valid_i && ready_o on an invalid entry or a tag mismatch SHALL allocate: valid = 1, tag = new tag, value = upd_data_i, conf = 0.
REQ-027 On a tag hit where the predicted value equals upd_data_i, SHALL saturating-increment conf (max 2**CONF_WIDTH-1), with no wrap.
REQ-028 On a tag hit where the predicted value differs from upd_data_i, SHALL set conf = 0 and value = upd_data_i.
REQ-029 mispredict_o SHALL equal upd_valid_i && upd_predicted_i && (upd_pred_data_i != upd_data_i), registered one cycle after the update, including when ready_o = 0.
REQ-030 Updates with ready_o = 0 SHALL not modify the table; updates arriving in the same cycle as flush_i SHALL be dropped.
REQ-031 A lookup and an update to the same index in the same cycle SHALL return pre-update contents (read-before-write).
REQ-032 All value arithmetic SHALL be modulo 2**`DATA_WIDTH.

Reset
REQ-033 rst_n low SHALL immediately force state = CLEAR, clr_idx = 0, and pred_valid_o, pred_taken_o, pred_data_o, mispredict_o and ready_o to 0.
REQ-034 After rst_n rises, ready_o SHALL assert after DEPTH clock edges, and no prediction SHALL issue before then.
REQ-035 Reset asserted mid-sweep or mid-update SHALL abort it, with no partial entry made visible.

Configuration
REQ-036 Macro LVPT_STRIDE_EN defined: each entry SHALL add a `DATA_WIDTH stride (cleared to 0 on allocate and sweep), and predicted value = value + stride.
REQ-037 With LVPT_STRIDE_EN, a hit-match SHALL set value = upd_data_i with stride unchanged; a hit-mismatch SHALL set stride = upd_data_i - value, value = upd_data_i, conf = 0.
REQ-038 Without LVPT_STRIDE_EN: no stride storage, and predicted value = value.

Verification
REQ-039 Reset then idle -> ready_o = 0 for 256 cycles, 1 on cycle 257; lookup during the sweep -> pred_valid_o = 0.
REQ-040 Three updates pc=0x400100, data=0x55 -> conf 0,1,2; next lookup -> pred_taken_o = 1, pred_data_o = 0x55 one cycle later.
REQ-041 Update pc=0x400100 with upd_predicted_i=1, pred 0x55, data 0x66 -> mispredict_o = 1 next cycle; next lookup -> pred_taken_o = 0, conf = 0.
REQ-042 pc=0x400100 trained, then update pc=0x800100 (same index, new tag) -> reallocated; lookup 0x400100 -> pred_taken_o = 0.
REQ-043 With LVPT_STRIDE_EN, updates 0x10, 0x14, 0x18, 0x1C, 0x20 -> lookup predicts 0x24; ten more matches -> conf stays 3.
REQ-044 flush_i during a trained state -> ready_o low 256 cycles; afterwards every lookup -> pred_taken_o = 0.
